// File: rtl/legv8_alu_pkg.sv
// Shared constants and types for the LEGv8 sliced add/subtract sequencer.
// Holds the datapath widths, FSM state enum and slice index type.
package legv8_alu_pkg;

  localparam int DATA_W     = 64;
  localparam int SLICE_W    = 16;
  localparam int NUM_SLICES = DATA_W / SLICE_W;
  localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [IDX_W-1:0] slice_idx_t;

  localparam slice_idx_t LAST_IDX = slice_idx_t'(NUM_SLICES - 1);

endpackage

// File: rtl/legv8_slice_add_seq.sv
// Multi-cycle 64-bit add/sub that time-multiplexes one external adder slice.
// Ports: clk, rst_n; start/sub/a/b request, ready/busy/done status,
//   result and NZCV flags; add_a/add_b/add_c_in to the slice and
//   add_sum/add_c_out back from it.
// Build option: LEGV8_ADDSEQ_FLAGS_EN enables the registered NZCV flags;
//   when undefined, the flag ports are tied to 0.
module legv8_slice_add_seq
  import legv8_alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              sub,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              flag_n,
  output logic              flag_z,
  output logic              flag_c,
  output logic              flag_v,
  output logic [SLICE_W-1:0] add_a,
  output logic [SLICE_W-1:0] add_b,
  output logic              add_c_in,
  input  logic [SLICE_W-1:0] add_sum,
  input  logic              add_c_out
);

  state_t      r_state;
  state_t      w_nxt;
  slice_idx_t  r_idx;
  logic        r_carry;
  logic        r_sub;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_res;
  logic [DATA_W-1:0] w_res_nxt;
  logic        w_run;
  logic        w_last;
  logic        w_accept;

  assign w_run    = (r_state == RUN);
  assign w_last   = w_run && (r_idx == LAST_IDX);
  assign w_accept = start && ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE:    if (start) w_nxt = RUN;
      RUN:     if (w_last) w_nxt = DONE;
      DONE:    w_nxt = start ? RUN : IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = (r_state == IDLE) || (r_state == DONE);
    busy  = w_run;
    done  = (r_state == DONE);
  end

  always_comb begin
    add_a    = '0;
    add_b    = '0;
    add_c_in = 1'b0;
    if (w_run) begin
      add_a    = r_a[int'(r_idx)*SLICE_W +: SLICE_W];
      add_b    = r_b[int'(r_idx)*SLICE_W +: SLICE_W];
      add_c_in = (r_idx == '0) ? r_sub : r_carry;
    end
  end

  // Result with the current slice merged in; feeds both the
  // register and the zero flag on the final slice.
  always_comb begin
    w_res_nxt = r_res;
    w_res_nxt[int'(r_idx)*SLICE_W +: SLICE_W] = add_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sub   <= 1'b0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_res   <= '0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= sub ? ~b : b;
      r_sub <= sub;
      r_idx <= '0;
      r_res <= '0;
    end else if (w_run) begin
      r_res   <= w_res_nxt;
      r_carry <= add_c_out;
      r_idx   <= w_last ? '0 : r_idx + 1'b1;
    end
  end

  assign result = r_res;

`ifdef LEGV8_ADDSEQ_FLAGS_EN
  logic r_n, r_z, r_c, r_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n <= 1'b0;
      r_z <= 1'b0;
      r_c <= 1'b0;
      r_v <= 1'b0;
    end else if (w_last) begin
      r_n <= add_sum[SLICE_W-1];
      r_z <= (w_res_nxt == '0);
      r_c <= add_c_out;
      r_v <= (r_a[DATA_W-1] == r_b[DATA_W-1]) &&
             (add_sum[SLICE_W-1] != r_a[DATA_W-1]);
    end
  end

  assign flag_n = r_n;
  assign flag_z = r_z;
  assign flag_c = r_c;
  assign flag_v = r_v;
`else
  assign flag_n = 1'b0;
  assign flag_z = 1'b0;
  assign flag_c = 1'b0;
  assign flag_v = 1'b0;
`endif

endmodule

// File: tb/tb_legv8_slice_add_seq.sv
// Directed bench for legv8_slice_add_seq with a 16-bit adder slice model.
// Checks latency, results, NZCV, back-to-back starts and async reset.
module tb_legv8_slice_add_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        ready, busy, done;
  logic [63:0] result;
  logic        flag_n, flag_z, flag_c, flag_v;
  logic [15:0] add_a, add_b, add_sum;
  logic        add_c_in, add_c_out;
  logic [16:0] w_sum17;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  assign w_sum17 = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_c_in};
  assign add_sum   = w_sum17[15:0];
  assign add_c_out = w_sum17[16];

  legv8_slice_add_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub),
    .a(a), .b(b), .ready(ready), .busy(busy), .done(done),
    .result(result), .flag_n(flag_n), .flag_z(flag_z),
    .flag_c(flag_c), .flag_v(flag_v), .add_a(add_a),
    .add_b(add_b), .add_c_in(add_c_in), .add_sum(add_sum),
    .add_c_out(add_c_out)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [3:0] fl(input logic [3:0] nzcv);
`ifdef LEGV8_ADDSEQ_FLAGS_EN
    return nzcv;
`else
    return 4'b0000;
`endif
  endfunction

  function automatic logic [3:0] nzcv_now();
    return {flag_n, flag_z, flag_c, flag_v};
  endfunction

  // Issue one op from IDLE; check latency, carry-in, result, flags.
  task automatic run_op(input string tag, input logic [63:0] ia,
                        input logic [63:0] ib, input logic isub,
                        input logic [63:0] er, input logic [3:0] ef);
    @(negedge clk);
    a = ia; b = ib; sub = isub; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    a = '0; b = '0; sub = 1'b0;
    @(negedge clk);
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    chk({tag, "_cin0"}, 64'(add_c_in), 64'(isub));
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({tag, "_nodone3"}, 64'(done), 64'd0);
    @(negedge clk);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_res"}, result, er);
    chk({tag, "_nzcv"}, 64'(nzcv_now()), 64'(fl(ef)));
    @(negedge clk);
    chk({tag, "_idle"}, 64'({ready, busy, done}), 64'b100);
  endtask

  initial begin
    #12;
    chk("rst_state", 64'({ready, busy, done}), 64'b100);
    chk("rst_res", result, 64'd0);
    chk("rst_flags", 64'(nzcv_now()), 64'd0);
    chk("rst_add", 64'({add_a, add_b, add_c_in}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("ripple", 64'h0000_0000_0000_FFFF, 64'd1, 1'b0,
           64'h0000_0000_0001_0000, 4'b0000);
    run_op("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
           64'd0, 4'b0110);
    run_op("ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
           64'h8000_0000_0000_0000, 4'b1001);
    run_op("sub_neg", 64'd5, 64'd7, 1'b1,
           64'hFFFF_FFFF_FFFF_FFFE, 4'b1000);
    run_op("sub_zero", 64'd7, 64'd7, 1'b1, 64'd0, 4'b0110);

    // Back-to-back with start held high throughout.
    @(negedge clk);
    a = 64'h1234; b = 64'h1; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 a = 64'hDEAD_BEEF; b = 64'h5555; sub = 1'b1;
    @(negedge clk);
    chk("b2b_cin0", 64'(add_c_in), 64'd0);
    @(negedge clk);
    chk("b2b_cin1", 64'(add_c_in), 64'd0);
    chk("b2b_ign", 64'(busy), 64'd1);
    repeat (2) @(negedge clk);
    chk("b2b_nodone", 64'(done), 64'd0);
    @(negedge clk);
    chk("b2b_done1", 64'(done), 64'd1);
    chk("b2b_res1", result, 64'h1235);
    chk("b2b_fl1", 64'(nzcv_now()), 64'(fl(4'b0000)));
    a = 64'h10; b = 64'h1; sub = 1'b1;
    @(posedge clk);
    #1 a = 64'h0; b = 64'h0; sub = 1'b0;
    @(negedge clk);
    chk("b2b_cin2", 64'(add_c_in), 64'd1);
    @(negedge clk);
    chk("b2b_cin3", 64'(add_c_in), 64'd1);
    repeat (3) @(negedge clk);
    chk("b2b_done2", 64'(done), 64'd1);
    chk("b2b_res2", result, 64'hF);
    chk("b2b_fl2", 64'(nzcv_now()), 64'(fl(4'b0010)));
    start = 1'b0;
    @(negedge clk);
    chk("b2b_idle", 64'({ready, busy, done}), 64'b100);

    // Async reset during the second RUN cycle.
    @(negedge clk);
    a = 64'hFFFF_FFFF; b = 64'h1; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_state", 64'({ready, busy, done}), 64'b100);
    chk("ar_res", result, 64'd0);
    chk("ar_add", 64'({add_a, add_b, add_c_in}), 64'd0);
    repeat (6) begin
      @(negedge clk);
      chk("ar_nodone", 64'(done), 64'd0);
    end
    rst_n = 1'b1;
    run_op("post_rst", 64'h0000_0001_0000_0000,
           64'h0000_0002_FFFF_FFFF, 1'b0,
           64'h0000_0003_FFFF_FFFF, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/legv8_slice_add_seq.md
Name: legv8_slice_add_seq

Overview:
- Multi-cycle 64-bit add/subtract sequencer for the LEGv8 datapath.
- Time-multiplexes one external 16-bit ripple adder slice over four cycles: feeds it operand slices and carry-in each cycle, captures its sum and carry-out.
- Sits between the ALU operand registers and the 16-bit adder instance.
- Produces a 64-bit result with NZCV flags on a start/done handshake.

Parameters:
- DATA_W, 64, operand/result width; must be a multiple of SLICE_W.
- SLICE_W, 16, width of the attached adder slice.
- NUM_SLICES, DATA_W/SLICE_W (4), cycles per operation; derived, not overridable.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled on rising clk when ready=1.
- sub  in  1  1 = a - b (b inverted, carry-in 1); 0 = a + b.
- a  in  DATA_W  operand A.
- b  in  DATA_W  operand B.
- ready  out  1  high in IDLE and DONE; start accepted.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse; result/flags valid.
- result  out  DATA_W  registered sum; held until next accepted start.
- flag_n, flag_z, flag_c, flag_v  out  1 each  NZCV of last result.
- add_a  out  SLICE_W  to adder slice operand a.
- add_b  out  SLICE_W  to adder slice operand b (already inverted when sub).
- add_c_in  out  1  to adder slice carry-in.
- add_sum  in  SLICE_W  from adder slice sum.
- add_c_out  in  1  from adder slice carry-out.

Behaviour:
- Reset (async, rst_n=0): state IDLE, idx=0, carry_q=0, a_q=b_q=result=0, sub_q=0, done=0, all flags 0, ready=1, busy=0. Reset mid-RUN abandons the operation and produces no done pulse.
- States and transitions:
  - IDLE: on start, go to RUN.
  - RUN: advance one slice per cycle; on idx==NUM_SLICES-1, go to DONE.
  - DONE: lasts one cycle. On start, go to RUN (back-to-back); otherwise go to IDLE.
- Accept (edge E): latch a_q=a, b_q=(sub ? ~b : b), sub_q=sub; idx=0; result cleared to 0.
- RUN, combinational to adder:
  - add_a = a_q[idx*SLICE_W +: SLICE_W]
  - add_b = b_q[same slice]
  - add_c_in = (idx==0) ? sub_q : carry_q
- RUN, each edge: result[idx slice] <= add_sum; carry_q <= add_c_out; idx++.
- Outside RUN, add_a, add_b and add_c_in drive 0.
- Latency: start accepted at edge E; slices captured at edges E+1..E+4; done=1 for the cycle following E+4. Result and flags update at E+4.
- Flags:
  - n = result[DATA_W-1]
  - z = (result==0)
  - c = final add_c_out (ARM convention: for subtract, c=1 means no borrow)
  - v = (a_q[MSB]==b_q[MSB]) && (sum[MSB]!=a_q[MSB])
- start while busy is ignored; inputs a, b and sub are don't-care outside the accepting edge.
- Wrap-around: the 64-bit result is modulo 2^64; the carry out of the top slice appears only on flag_c.
- idx never exceeds NUM_SLICES-1.

Optional Feature:
- LEGV8_ADDSEQ_FLAGS_EN
  - Defined: NZCV computed and registered as above.
  - Undefined: flag_n, flag_z, flag_c and flag_v are tied to 0, and no flag registers are synthesized. Ports remain present.

Decomposition:
- Shared package legv8_alu_pkg:
  - state enum {IDLE, RUN, DONE}
  - DATA_W=64 and SLICE_W=16 constants
  - NUM_SLICES
  - slice index typedef of width $clog2(NUM_SLICES)
- No sub-module inside this block. The 16-bit adder slice is instantiated beside it at the next level up and wired through the add_* ports.

Test Plan:
- a=0x0000_0000_0000_FFFF, b=1, sub=0 → done 4 cycles after accept; result=0x0000_0000_0001_0000; carry ripples across a slice boundary; NZCV=0000.
- a=0xFFFF_FFFF_FFFF_FFFF, b=1, sub=0 → result=0; NZCV=0110.
- a=0x7FFF_FFFF_FFFF_FFFF, b=1, sub=0 → result=0x8000_0000_0000_0000; NZCV=1001.
- a=5, b=7, sub=1 → result=0xFFFF_FFFF_FFFF_FFFE; NZCV=1000. Then a=7, b=7, sub=1 → result=0; NZCV=0110.
- start held high continuously with new operands → each accepted in the DONE cycle; one done pulse per 5 cycles; starts during RUN ignored; add_c_in=sub only in the first RUN cycle.
- rst_n pulled low at the 2nd RUN cycle → outputs clear immediately, asynchronously; no done pulse; next start after release completes normally with the correct result.
